// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core memory stage: access-size encodings,
// the data-memory FSM states and the alignment rule.
package mips_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mau_state_t;

  // Size 2'b11 falls into the word rule.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load-path lane select and sign/zero extension of the raw data-memory word.
module mem_load_align
  import mips_pkg::*;
(
  input  logic [31:0] dmem_rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_unsigned_i,
  output logic [31:0] load_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = dmem_rdata_i[7:0];
      2'd1:    byte_sel = dmem_rdata_i[15:8];
      2'd2:    byte_sel = dmem_rdata_i[23:16];
      default: byte_sel = dmem_rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];

    case (mem_size_i)
      SZ_BYTE: load_data_o = {{24{~mem_unsigned_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data_o = {{16{~mem_unsigned_i & half_sel[15]}}, half_sel};
      default: load_data_o = dmem_rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: turns EX/MEM load/store controls into one req/ack bus transaction,
// stalling the pipeline until the bus completes or times out.
//
// state | meaning
// IDLE  | waiting for an aligned access; stalls in the cycle one is seen
// BUSY  | dmem_req held, waiting for dmem_ack or timeout
// DONE  | one stall-free cycle, read_data/bus_err valid for MEMWB
module mem_access_unit
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  output logic [31:0] read_data_o,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ack_i
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  mau_state_t  state_q;
  logic [CW-1:0] cnt_q;
  logic        req_q, we_q, err_q, uns_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  be_q;
  logic [1:0]  off_q, size_q;

  logic        access, mis, start;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, load_ext;

  always_comb begin
    access = mem_read_i | mem_write_i;
    mis    = access & is_misaligned(mem_size_i, addr_i[1:0]);
    start  = access & ~mis;

    st_be    = 4'b1111;
    st_wdata = store_data_i;
    case (mem_size_i)
      SZ_BYTE: begin
        st_be    = 4'b0001 << addr_i[1:0];
        st_wdata = {4{store_data_i[7:0]}};
      end
      SZ_HALF: begin
        st_be    = 4'b0011 << {addr_i[1], 1'b0};
        st_wdata = {2{store_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane/extension controls come from the registered copy taken at issue.
  mem_load_align u_load_align (
    .dmem_rdata_i  (dmem_rdata_i),
    .addr_lo_i     (off_q),
    .mem_size_i    (size_q),
    .mem_unsigned_i(uns_q),
    .load_data_o   (load_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= '0;
      off_q   <= '0;
      size_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q  <= {addr_i[31:2], 2'b00};
            we_q    <= mem_write_i;
            be_q    <= mem_write_i ? st_be : 4'b1111;
            wdata_q <= st_wdata;
            off_q   <= addr_i[1:0];
            size_q  <= mem_size_i;
            uns_q   <= mem_unsigned_i;
            err_q   <= 1'b0;
            req_q   <= 1'b1;
            cnt_q   <= CW'(TIMEOUT - 1);
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (dmem_ack_i) begin
            rdata_q <= load_ext;
            req_q   <= 1'b0;
            state_q <= DONE;
          end else if (cnt_q == '0) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            req_q   <= 1'b0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    stall_o     = (state_q == BUSY) | ((state_q == IDLE) & start);
    misalign_o  = mis;
    read_data_o = (state_q == DONE) ? rdata_q : 32'h0;
    bus_err_o   = (state_q == DONE) & err_q;
  end

  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed table, hand-written reset
// sequence and randomized accesses against an arithmetic reference model.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0, mem_unsigned = 1'b0;
  logic [1:0]  mem_size = 2'b00;
  logic [31:0] addr = '0, store_data = '0, dmem_rdata = '0;
  logic        dmem_ack = 1'b0;
  logic [31:0] read_data, dmem_addr, dmem_wdata;
  logic        stall, misalign, bus_err, dmem_req, dmem_we;
  logic [3:0]  dmem_be;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rd, wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr, sd, mw;
    int          delay;
  } vec_t;

  typedef struct {
    logic [31:0] rdata, wdata;
    logic [3:0]  be;
    logic        mis, err, we, chk_rdata;
    int          stall, req;
  } exp_t;

  typedef struct {
    vec_t v;
    exp_t e;
  } rec_t;

  typedef struct {
    logic        mis, req_early, req_late, done, err, we, unstable;
    logic [31:0] rdata, wdata, addr;
    logic [3:0]  be;
    int          stall, req;
  } obs_t;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_read_i    (mem_read),
    .mem_write_i   (mem_write),
    .mem_size_i    (mem_size),
    .mem_unsigned_i(mem_unsigned),
    .addr_i        (addr),
    .store_data_i  (store_data),
    .read_data_o   (read_data),
    .stall_o       (stall),
    .misalign_o    (misalign),
    .bus_err_o     (bus_err),
    .dmem_req_o    (dmem_req),
    .dmem_we_o     (dmem_we),
    .dmem_addr_o   (dmem_addr),
    .dmem_be_o     (dmem_be),
    .dmem_wdata_o  (dmem_wdata),
    .dmem_rdata_i  (dmem_rdata),
    .dmem_ack_i    (dmem_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(logic rd, logic wr, logic [1:0] sz, logic uns,
                               logic [31:0] a, logic [31:0] sd, logic [31:0] mw, int dly);
    vec_t v;
    v = '{rd, wr, sz, uns, a, sd, mw, dly};
    return v;
  endfunction

  function automatic exp_t mke(logic [31:0] rdata, logic [31:0] wdata, logic [3:0] be,
                               logic mis, logic err, logic we, logic chk_rdata, int st, int rq);
    exp_t e;
    e = '{rdata, wdata, be, mis, err, we, chk_rdata, st, rq};
    return e;
  endfunction

  // Reference: bus and result expectations derived from byte counts and shifts.
  function automatic exp_t model(vec_t v);
    exp_t        e;
    int unsigned off, nb, w;
    logic        tmo;
    e = mke(32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    off = v.addr % 4;
    nb  = (v.sz == 2'd0) ? 1 : (v.sz == 2'd1) ? 2 : 4;
    e.mis = (off % nb) != 0;
    if (e.mis) return e;
    tmo = (v.delay >= TO);
    e.err   = tmo;
    e.we    = v.wr;
    e.req   = tmo ? TO : v.delay + 1;
    e.stall = e.req + 1;
    e.be    = v.wr ? 4'(((1 << nb) - 1) << off) : 4'hF;
    e.wdata = (nb == 1) ? v.sd[7:0] * 32'h01010101 :
              (nb == 2) ? v.sd[15:0] * 32'h00010001 : v.sd;
    w = v.mw >> (8 * off);
    if (nb == 1) begin
      w = w % 256;
      if (!v.uns && w >= 128) w = w - 256;
    end else if (nb == 2) begin
      w = w % 65536;
      if (!v.uns && w >= 32768) w = w - 65536;
    end
    e.chk_rdata = !v.wr || tmo;
    e.rdata     = tmo ? 32'h0 : w;
    return e;
  endfunction

  // Entered and left at posedge+2 with the DUT idle; plays the memory side.
  task automatic run_acc(input vec_t v, output obs_t o);
    o = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 0, 0};
    mem_read = v.rd; mem_write = v.wr; mem_size = v.sz; mem_unsigned = v.uns;
    addr = v.addr; store_data = v.sd;
    #1;
    o.mis = misalign;
    o.req_early = dmem_req;
    if (!stall) begin
      o.rdata = read_data;
      repeat (3) begin
        @(posedge clk); #2;
        if (dmem_req) o.req++;
        if (stall) o.stall++;
      end
    end else begin
      o.stall = 1;
      for (int k = 0; k < TO + 4; k++) begin
        @(posedge clk); #1; dmem_ack = 1'b0; #1;
        if (!stall) begin
          o.done = 1'b1; o.rdata = read_data; o.err = bus_err; o.req_late = dmem_req;
          break;
        end
        o.stall++;
        if (dmem_req) begin
          if (o.req == 0) begin
            o.addr = dmem_addr; o.be = dmem_be; o.we = dmem_we; o.wdata = dmem_wdata;
          end else if ({dmem_addr, dmem_be, dmem_we, dmem_wdata} != {o.addr, o.be, o.we, o.wdata}) begin
            o.unstable = 1'b1;
          end
          o.req++;
        end
        dmem_rdata = (k == v.delay) ? v.mw : $urandom;
        dmem_ack   = (k == v.delay);
      end
    end
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0; dmem_ack = 1'b0;
    #1;
  endtask

  task automatic apply(input string tag, input vec_t v, input exp_t e);
    obs_t o;
    run_acc(v, o);
    chk({tag, ".misalign"}, 32'(o.mis), 32'(e.mis));
    chk({tag, ".stall_cycles"}, 32'(o.stall), 32'(e.stall));
    chk({tag, ".req_cycles"}, 32'(o.req), 32'(e.req));
    chk({tag, ".req_in_idle"}, 32'(o.req_early), 32'h0);
    if (e.chk_rdata) chk({tag, ".read_data"}, o.rdata, e.rdata);
    if (!e.mis) begin
      chk({tag, ".done_reached"}, 32'(o.done), 32'h1);
      chk({tag, ".bus_err"}, 32'(o.err), 32'(e.err));
      chk({tag, ".req_after"}, 32'(o.req_late), 32'h0);
      chk({tag, ".dmem_addr"}, o.addr, v.addr & 32'hFFFF_FFFC);
      chk({tag, ".dmem_be"}, 32'(o.be), 32'(e.be));
      chk({tag, ".dmem_we"}, 32'(o.we), 32'(e.we));
      chk({tag, ".bus_stable"}, 32'(o.unstable), 32'h0);
      if (e.we) chk({tag, ".dmem_wdata"}, o.wdata, e.wdata);
    end
  endtask

  rec_t tbl[$];
  vec_t rv;
  logic late_seen;

  initial begin
    tbl.push_back('{mkv(1, 0, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0),
                    mke(32'hDEADBEEF, 32'h0, 4'hF, 0, 0, 0, 1, 2, 1)});
    tbl.push_back('{mkv(1, 0, 2'b00, 0, 32'h103, 32'h0, 32'h80123456, 1),
                    mke(32'hFFFFFF80, 32'h0, 4'hF, 0, 0, 0, 1, 3, 2)});
    tbl.push_back('{mkv(1, 0, 2'b00, 1, 32'h103, 32'h0, 32'h80123456, 2),
                    mke(32'h00000080, 32'h0, 4'hF, 0, 0, 0, 1, 4, 3)});
    tbl.push_back('{mkv(0, 1, 2'b01, 0, 32'h202, 32'h0000ABCD, 32'h0, 0),
                    mke(32'h0, 32'hABCDABCD, 4'hC, 0, 0, 1, 0, 2, 1)});
    tbl.push_back('{mkv(1, 0, 2'b10, 0, 32'h101, 32'h0, 32'h11111111, 0),
                    mke(32'h0, 32'h0, 4'h0, 1, 0, 0, 1, 0, 0)});
    tbl.push_back('{mkv(1, 0, 2'b10, 0, 32'h300, 32'h0, 32'h55555555, 99),
                    mke(32'h0, 32'h0, 4'hF, 0, 1, 0, 1, 5, 4)});
    tbl.push_back('{mkv(1, 0, 2'b01, 0, 32'h106, 32'h0, 32'h80017FFF, 3),
                    mke(32'hFFFF8001, 32'h0, 4'hF, 0, 0, 0, 1, 5, 4)});
    tbl.push_back('{mkv(0, 1, 2'b00, 0, 32'h105, 32'h123456A5, 32'h0, 0),
                    mke(32'h0, 32'hA5A5A5A5, 4'h2, 0, 0, 1, 0, 2, 1)});
    tbl.push_back('{mkv(0, 1, 2'b01, 0, 32'h203, 32'h1234, 32'h0, 0),
                    mke(32'h0, 32'h0, 4'h0, 1, 0, 0, 1, 0, 0)});
    tbl.push_back('{mkv(1, 0, 2'b11, 0, 32'h40, 32'h0, 32'h12345678, 1),
                    mke(32'h12345678, 32'h0, 4'hF, 0, 0, 0, 1, 3, 2)});
    tbl.push_back('{mkv(1, 0, 2'b01, 1, 32'h10, 32'h0, 32'hFFFF8001, 0),
                    mke(32'h00008001, 32'h0, 4'hF, 0, 0, 0, 1, 2, 1)});
    tbl.push_back('{mkv(1, 1, 2'b10, 0, 32'h20, 32'hCAFEF00D, 32'h0, 0),
                    mke(32'h0, 32'hCAFEF00D, 4'hF, 0, 0, 1, 0, 2, 1)});
    tbl.push_back('{mkv(0, 1, 2'b00, 0, 32'h1, 32'h7E, 32'h0, 5),
                    mke(32'h0, 32'h7E7E7E7E, 4'h2, 0, 1, 1, 1, 5, 4)});

    // Reset values with the async reset still asserted.
    #3;
    chk("reset.stall", 32'(stall), 32'h0);
    chk("reset.dmem_req", 32'(dmem_req), 32'h0);
    chk("reset.read_data", read_data, 32'h0);
    chk("reset.bus_fields", {dmem_addr[31:4], dmem_be ^ dmem_addr[3:0]}, 32'h0);
    chk("reset.wdata_we", dmem_wdata | 32'(dmem_we) | 32'(bus_err) | 32'(misalign), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("idle.stall", 32'(stall), 32'h0);
    chk("idle.misalign", 32'(misalign), 32'h0);

    foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i].v, tbl[i].e);

    // Reset on the second BUSY cycle, then a stray ack after release.
    mem_read = 1'b1; mem_write = 1'b0; mem_size = 2'b10; addr = 32'h100;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rstmid.busy_req", 32'(dmem_req), 32'h1);
    rst_n = 1'b0; mem_read = 1'b0;
    #1;
    chk("rstmid.req_drop", 32'(dmem_req), 32'h0);
    chk("rstmid.stall", 32'(stall), 32'h0);
    chk("rstmid.dmem_addr", dmem_addr, 32'h0);
    chk("rstmid.dmem_be", 32'(dmem_be), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    dmem_rdata = 32'hA5A5A5A5; dmem_ack = 1'b1;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    late_seen = 1'b0;
    repeat (4) begin
      #1;
      if (stall || dmem_req || bus_err || read_data != 0) late_seen = 1'b1;
      @(posedge clk); #1;
    end
    #1;
    chk("rstmid.late_ack_ignored", 32'(late_seen), 32'h0);
    apply("post_reset", tbl[0].v, tbl[0].e);

    for (int n = 0; n < 60; n++) begin
      rv.rd    = 1'($urandom);
      rv.wr    = 1'($urandom);
      if (!rv.rd && !rv.wr) rv.rd = 1'b1;
      rv.sz    = 2'($urandom);
      rv.uns   = 1'($urandom);
      rv.addr  = $urandom;
      if ($urandom_range(0, 3) != 0) rv.addr[1:0] = (rv.sz == 2'd1) ? {rv.addr[1], 1'b0} :
                                                     (rv.sz == 2'd0) ? rv.addr[1:0] : 2'b00;
      rv.sd    = $urandom;
      rv.mw    = $urandom;
      rv.delay = $urandom_range(0, TO + 1);
      apply($sformatf("rnd%0d", n), rv, model(rv));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
